display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, clock cycles per digit slot; legal range 4 or more.
REQ-002 SHALL have parameter BLANK_CYC, default 1000, inter-digit blanking cycles at the start of each slot; legal range 1 to CLK_DIV-1.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous reset, active-low.
REQ-005 SHALL have port dig_in  input  32  eight hex nibbles; nibble i (dig_in[4i+3:4i]) is digit i.
REQ-006 SHALL have port dig_valid  input  1  single-cycle load strobe for dig_in.
REQ-007 SHALL have port blank_lz  input  1  leading-zero suppression enable, sampled live.
REQ-008 SHALL have port dp_mask  input  8  decimal-point enable per digit, active-high, sampled live.
REQ-009 SHALL have port an  output  8  digit enables, active-low, one-hot-low or all-ones.
REQ-010 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp  output  1  decimal point, active-low.
REQ-012 SHALL have port num  output  3  index of the current digit slot.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse marking the start of a new frame.

Function
REQ-014 SHALL hold a slot counter cnt (0..CLK_DIV-1), a digit index num, a 32-bit shadow register, a 32-bit pending register and a pending flag.
REQ-015 SHALL run a two-state FSM: BLANK while cnt < BLANK_CYC, DRIVE for the remaining CLK_DIV-BLANK_CYC cycles of the slot.
REQ-016 SHALL, on the edge where cnt==CLK_DIV-1: set cnt to 0, enter BLANK and advance num by 1, wrapping 7->0.
REQ-017 SHALL, on the wrapping edge (num 7->0): copy pending to shadow if the pending flag is set, clear the flag and assert frame_done for exactly the following cycle.
REQ-018 SHALL, on dig_valid=1, capture dig_in into pending and set the pending flag; a later strobe before the frame boundary overwrites pending (last write wins).
REQ-019 SHALL, when dig_valid=1 coincides with the wrapping edge, load dig_in directly into shadow and leave the pending flag clear.
REQ-020 SHALL never change shadow except at a frame boundary, so that a frame is never torn.
REQ-021 SHALL drive an=8'hFF, seg=7'h7F and dp=1 in BLANK.
REQ-022 SHALL, in DRIVE, drive an with bit num low and all other bits high; seg is the decode of shadow nibble num; dp is ~dp_mask[num].
REQ-023 SHALL decode nibble values 0-F to seg as: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-024 SHALL, when blank_lz=1 and num!=0 and shadow nibbles num..7 are all zero, keep an=8'hFF and seg=7'h7F for that DRIVE slot; dp still follows dp_mask.
REQ-025 SHALL always display digit 0 regardless of blank_lz.
REQ-026 SHALL derive an, seg, dp, num and frame_done only from registered state and the live inputs blank_lz/dp_mask; there is no combinational path from dig_in or dig_valid.

Reset
REQ-027 SHALL, on the rst_n=0 sampling edge, set cnt=0, num=0, state=BLANK, shadow=0, pending=0, pending flag=0 and frame_done=0, so that an=8'hFF, seg=7'h7F and dp=1.
REQ-028 SHALL let reset mid-slot or mid-frame discard any pending load and restart at digit 0 BLANK on the first cycle with rst_n=1.
REQ-029 SHALL let rst_n override dig_valid in the same cycle.

Verification (CLK_DIV=8, BLANK_CYC=2)
REQ-030 SHALL cover this scenario: release reset with no load -> cycles 0-1 an=FF; cycles 2-7 an=FE, seg=40; cycle 8 num=1 with an=FF; first frame_done at cycle 64.
REQ-031 SHALL cover this scenario: dig_valid with dig_in=0x89ABCDEF at cycle 10 -> digits keep showing 0 until cycle 64; from the next frame, digit 0 shows seg=0E and digit 7 shows seg=00.
REQ-032 SHALL cover this scenario: dig_valid at cycles 20 (0x11111111) and 30 (0x22222222) -> the next frame shows all digits seg=24; 0x11111111 is never shown.
REQ-033 SHALL cover this scenario: dig_valid with dig_in=0x00000305 on the wrapping edge -> that frame shows it immediately; with blank_lz=1, digits 3-7 show an=FF while digits 0-2 show 12, 40, 30.
REQ-034 SHALL cover this scenario: dp_mask=8'h04 -> dp=0 only during the DRIVE phase of digit 2; dp=1 in all BLANK phases.
REQ-035 SHALL cover this scenario: rst_n low at cycle 37 with a load pending -> an=FF, num=0, shadow=0 on release; the pending value is never displayed.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with per-slot blanking,
// frame-aligned double buffering of the digit word and leading-zero suppression.
module display_scan_ctrl #(
    parameter int unsigned CLK_DIV   = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dig_in,
    input  logic        dig_valid,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  num,
    output logic        frame_done
);

    localparam int unsigned      CntW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

    typedef enum logic {StBlank, StDrive} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      num_q, num_d;
    logic [31:0]     shadow_q, shadow_d;
    logic [31:0]     pending_q, pending_d;
    logic            pend_q, pend_d;
    logic            fd_q, fd_d;

    logic            slot_end;
    logic            frame_end;
    logic [3:0]      nib;
    logic [6:0]      seg_dec;
    logic [7:0]      upper_zero;
    logic            zero_run;
    logic            lz_blank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StBlank;
            cnt_q     <= '0;
            num_q     <= 3'd0;
            shadow_q  <= 32'h0;
            pending_q <= 32'h0;
            pend_q    <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            fd_q      <= fd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        num_d     = num_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        slot_end  = (cnt_q == CntLast);
        frame_end = slot_end && (num_q == 3'd7);
        fd_d      = frame_end;

        if (slot_end) begin
            cnt_d   = '0;
            state_d = StBlank;
            num_d   = num_q + 3'd1;
        end else if (cnt_q == BlankLast) begin
            state_d = StDrive;
        end

        // Shadow only moves at the frame boundary; a strobe on that edge bypasses pending.
        if (frame_end) begin
            if (dig_valid) begin
                shadow_d = dig_in;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                shadow_d = pending_q;
                pend_d   = 1'b0;
            end
        end else if (dig_valid) begin
            pending_d = dig_in;
            pend_d    = 1'b1;
        end
    end

    // upper_zero[i] is set when shadow nibbles i..7 are all zero.
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            zero_run      = zero_run & (shadow_q[4*i +: 4] == 4'h0);
            upper_zero[i] = zero_run;
        end
    end

    always_comb begin
        nib = shadow_q[{num_q, 2'b00} +: 4];
        unique case (nib)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
        endcase
    end

    always_comb begin
        lz_blank = blank_lz && (num_q != 3'd0) && upper_zero[num_q];
        an       = 8'hFF;
        seg      = 7'h7F;
        dp       = 1'b1;
        if (state_q == StDrive) begin
            dp = ~dp_mask[num_q];
            if (!lz_blank) begin
                an  = ~(8'b1 << num_q);
                seg = seg_dec;
            end
        end
    end

    assign num        = num_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl at CLK_DIV=8, BLANK_CYC=2: directed scenarios
// queue expected outputs per cycle, a negedge monitor pops and compares them.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dig_in = 32'h0;
    logic        dig_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  dp_mask = 8'h00;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  num;
    logic        frame_done;

    display_scan_ctrl #(
        .CLK_DIV   (8),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dig_in     (dig_in),
        .dig_valid  (dig_valid),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .num        (num),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] num;
        logic       fd;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Cycle 0 is the first cycle after the last reset-sampling edge.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_cmp++;
                if (e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s: check for cycle %0d not reached in order (now cycle %0d)",
                             e.name, e.cyc, cyc);
                end else if ({an, seg, dp, num, frame_done} !== {e.an, e.seg, e.dp, e.num, e.fd})
                begin
                    n_err++;
                    $display("FAIL %s @%0d: got an=%h seg=%h dp=%b num=%0d fd=%b, exp an=%h seg=%h dp=%b num=%0d fd=%b",
                             e.name, cyc, an, seg, dp, num, frame_done,
                             e.an, e.seg, e.dp, e.num, e.fd);
                end
            end
        end
    end

    task automatic exp_at(input int c, input logic [7:0] a, input logic [6:0] s, input logic d,
                          input logic [2:0] n, input logic f, input string nm);
        exp_t e;
        e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.num = n; e.fd = f; e.name = nm;
        q.push_back(e);
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        dig_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic strobe(input int k, input logic [31:0] val);
        goto(k);
        dig_in    = val;
        dig_valid = 1'b1;
        @(posedge clk);
        #1;
        dig_valid = 1'b0;
    endtask

    task automatic end_scn(input int last, input string nm);
        goto(last + 1);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s drain: %0d checks left, exp 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, exp finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up with no load
        blank_lz = 1'b0; dp_mask = 8'h00;
        do_reset();
        exp_at(0,  8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0, "s1_reset");
        exp_at(1,  8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0, "s1_blank1");
        exp_at(2,  8'hFE, 7'h40, 1'b1, 3'd0, 1'b0, "s1_drive0");
        exp_at(7,  8'hFE, 7'h40, 1'b1, 3'd0, 1'b0, "s1_slot0_end");
        exp_at(8,  8'hFF, 7'h7F, 1'b1, 3'd1, 1'b0, "s1_num1_blank");
        exp_at(10, 8'hFD, 7'h40, 1'b1, 3'd1, 1'b0, "s1_drive1");
        exp_at(63, 8'h7F, 7'h40, 1'b1, 3'd7, 1'b0, "s1_drive7");
        exp_at(64, 8'hFF, 7'h7F, 1'b1, 3'd0, 1'b1, "s1_frame_done");
        exp_at(65, 8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0, "s1_fd_one_cycle");
        end_scn(65, "s1");

        // Load goes to pending, appears next frame
        do_reset();
        exp_at(12,  8'hFD, 7'h40, 1'b1, 3'd1, 1'b0, "s2_still_zero1");
        exp_at(58,  8'h7F, 7'h40, 1'b1, 3'd7, 1'b0, "s2_still_zero7");
        exp_at(64,  8'hFF, 7'h7F, 1'b1, 3'd0, 1'b1, "s2_frame_done");
        exp_at(66,  8'hFE, 7'h0E, 1'b1, 3'd0, 1'b0, "s2_dig0_F");
        exp_at(84,  8'hFB, 7'h21, 1'b1, 3'd2, 1'b0, "s2_dig2_D");
        exp_at(122, 8'h7F, 7'h00, 1'b1, 3'd7, 1'b0, "s2_dig7_8");
        strobe(10, 32'h89ABCDEF);
        end_scn(122, "s2");

        // Last write wins
        do_reset();
        exp_at(26,  8'hF7, 7'h40, 1'b1, 3'd3, 1'b0, "s3_no_tear");
        exp_at(66,  8'hFE, 7'h24, 1'b1, 3'd0, 1'b0, "s3_dig0_2");
        exp_at(100, 8'hEF, 7'h24, 1'b1, 3'd4, 1'b0, "s3_dig4_2");
        exp_at(126, 8'h7F, 7'h24, 1'b1, 3'd7, 1'b0, "s3_dig7_2");
        strobe(20, 32'h11111111);
        strobe(30, 32'h22222222);
        end_scn(126, "s3");

        // Strobe on the wrapping edge, leading-zero suppression
        blank_lz = 1'b1;
        do_reset();
        exp_at(2,   8'hFE, 7'h40, 1'b1, 3'd0, 1'b0, "s4_dig0_always");
        exp_at(42,  8'hFF, 7'h7F, 1'b1, 3'd5, 1'b0, "s4_lz_zero_word");
        exp_at(64,  8'hFF, 7'h7F, 1'b1, 3'd0, 1'b1, "s4_frame_done");
        exp_at(66,  8'hFE, 7'h12, 1'b1, 3'd0, 1'b0, "s4_dig0_5");
        exp_at(74,  8'hFD, 7'h40, 1'b1, 3'd1, 1'b0, "s4_dig1_inner0");
        exp_at(82,  8'hFB, 7'h30, 1'b1, 3'd2, 1'b0, "s4_dig2_3");
        exp_at(90,  8'hFF, 7'h7F, 1'b1, 3'd3, 1'b0, "s4_dig3_lz");
        exp_at(122, 8'hFF, 7'h7F, 1'b1, 3'd7, 1'b0, "s4_dig7_lz");
        exp_at(129, 8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0, "s4_no_reload");
        strobe(63, 32'h00000305);
        end_scn(129, "s4");

        // Decimal point mask, live blank_lz change
        blank_lz = 1'b0;
        dp_mask  = 8'h04;
        do_reset();
        exp_at(16, 8'hFF, 7'h7F, 1'b1, 3'd2, 1'b0, "s5_dp_blank16");
        exp_at(17, 8'hFF, 7'h7F, 1'b1, 3'd2, 1'b0, "s5_dp_blank17");
        exp_at(18, 8'hFB, 7'h40, 1'b0, 3'd2, 1'b0, "s5_dp_on18");
        exp_at(23, 8'hFB, 7'h40, 1'b0, 3'd2, 1'b0, "s5_dp_on23");
        exp_at(24, 8'hFF, 7'h7F, 1'b1, 3'd3, 1'b0, "s5_dp_blank24");
        exp_at(26, 8'hF7, 7'h40, 1'b1, 3'd3, 1'b0, "s5_dp_off26");
        exp_at(74, 8'hFF, 7'h7F, 1'b1, 3'd1, 1'b0, "s5_lz_dig1");
        exp_at(80, 8'hFF, 7'h7F, 1'b1, 3'd2, 1'b0, "s5_lz_blank80");
        exp_at(82, 8'hFF, 7'h7F, 1'b0, 3'd2, 1'b0, "s5_lz_dp_kept");
        goto(70);
        blank_lz = 1'b1;
        end_scn(82, "s5");

        // Reset mid-slot with a load pending; reset beats dig_valid
        blank_lz = 1'b0;
        dp_mask  = 8'h00;
        do_reset();
        exp_at(2,  8'hFE, 7'h40, 1'b1, 3'd0, 1'b0, "s6_pre_dig0");
        exp_at(26, 8'hF7, 7'h40, 1'b1, 3'd3, 1'b0, "s6_pre_dig3");
        strobe(20, 32'h12345678);
        goto(37);
        dig_in    = 32'hFFFFFFFF;
        dig_valid = 1'b1;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        dig_valid = 1'b0;
        exp_at(0,  8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0, "s6_post_reset");
        exp_at(2,  8'hFE, 7'h40, 1'b1, 3'd0, 1'b0, "s6_post_dig0");
        exp_at(8,  8'hFF, 7'h7F, 1'b1, 3'd1, 1'b0, "s6_post_num1");
        exp_at(64, 8'hFF, 7'h7F, 1'b1, 3'd0, 1'b1, "s6_frame_done");
        exp_at(66, 8'hFE, 7'h40, 1'b1, 3'd0, 1'b0, "s6_pending_dropped");
        exp_at(74, 8'hFD, 7'h40, 1'b1, 3'd1, 1'b0, "s6_override_dropped");
        end_scn(74, "s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
